// File: rtl/torus_pkg.sv
// ============================================================================
// Module  : torus_pkg
// Brief   : Shared types and defaults for the torus systolic array sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package torus_pkg;

  localparam int N_DEF       = 4;
  localparam int K_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } ctrl_state_e;

  // Feed counter width: wide enough for K + N - 2 at the largest K.
  function automatic int cnt_width(input int kw, input int n);
    return kw + $clog2(n);
  endfunction

  localparam int CNT_W_DEF = cnt_width(K_WIDTH_DEF, N_DEF);

endpackage

`default_nettype wire

// File: rtl/torus_skew_gen.sv
// ============================================================================
// Module  : torus_skew_gen
// Brief   : Diagonal skew enables: lane i is active while i <= c < i + K.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module torus_skew_gen
  import torus_pkg::*;
#(
  parameter int N_P       = N_DEF,
  parameter int K_WIDTH_P = K_WIDTH_DEF
) (
  input  logic                                 i_act,
  input  logic [cnt_width(K_WIDTH_P, N_P)-1:0] i_cnt,
  input  logic [K_WIDTH_P-1:0]                 i_k,
  output logic [N_P-1:0]                       o_en
);

  localparam int CW = cnt_width(K_WIDTH_P, N_P);
  localparam int XW = CW + 1;

  logic [XW-1:0] w_cnt_x;
  logic [XW-1:0] w_k_x;

  assign w_cnt_x = {1'b0, i_cnt};
  assign w_k_x   = {{(XW - K_WIDTH_P){1'b0}}, i_k};

  for (genvar i = 0; i < N_P; i++) begin : g_lane
    logic [XW-1:0] w_lo;
    logic [XW-1:0] w_hi;
    assign w_lo    = XW'(i);
    assign w_hi    = XW'(i) + w_k_x;
    assign o_en[i] = i_act & (w_cnt_x >= w_lo) & (w_cnt_x < w_hi);
  end

endmodule

`default_nettype wire

// File: rtl/torus_array_ctrl.sv
// ============================================================================
// Module  : torus_array_ctrl
// Brief   : Command sequencer for an N_P x N_P torus systolic array:
//           clear, skewed feed, flush, and row drain with backpressure.
//           Optional perf counters under `TORUS_CTRL_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module torus_array_ctrl
  import torus_pkg::*;
#(
  parameter int N_P       = N_DEF,
  parameter int K_WIDTH_P = K_WIDTH_DEF
) (
  input  logic                                 clk_i,
  input  logic                                 reset_n,
  input  logic                                 cmd_v_i,
  input  logic [K_WIDTH_P-1:0]                 cmd_k_i,
  output logic                                 cmd_ready_o,
  output logic                                 psum_clear_o,
  output logic [N_P-1:0]                       feed_row_en_o,
  output logic [N_P-1:0]                       feed_col_en_o,
  output logic [K_WIDTH_P+$clog2(N_P)-1:0]     feed_idx_o,
  output logic                                 drain_v_o,
  output logic [$clog2(N_P)-1:0]               drain_row_o,
  input  logic                                 drain_ready_i,
  output logic                                 busy_o,
  output logic                                 done_o
`ifdef TORUS_CTRL_PERF_EN
  ,
  output logic [31:0]                          perf_cycles_o,
  output logic [31:0]                          perf_stall_o
`endif
);

  localparam int RW = $clog2(N_P);
  localparam int CW = cnt_width(K_WIDTH_P, N_P);
  localparam int XW = CW + 1;

  ctrl_state_e          r_state;
  ctrl_state_e          w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [RW-1:0]        r_row;
  logic [K_WIDTH_P-1:0] r_k;

  logic                 w_accept;
  logic                 w_feed_act;
  logic                 w_feed_last;
  logic                 w_flush_last;
  logic                 w_drain_fire;
  logic                 w_drain_last;
  logic [N_P-1:0]       w_en;
  logic [XW-1:0]        w_feed_end;

  assign w_accept     = cmd_v_i & (r_state == ST_IDLE);
  assign w_feed_end   = {{(XW - K_WIDTH_P){1'b0}}, r_k} + XW'(N_P - 2);
  assign w_feed_last  = ({1'b0, r_cnt} == w_feed_end);
  assign w_flush_last = (r_cnt == CW'(N_P - 1));
  assign w_drain_fire = (r_state == ST_DRAIN) & drain_ready_i;
  assign w_drain_last = w_drain_fire & (r_row == RW'(N_P - 1));

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    cmd_ready_o  = 1'b0;
    psum_clear_o = 1'b0;
    w_feed_act   = 1'b0;
    drain_v_o    = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (cmd_v_i) w_state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        psum_clear_o = 1'b1;
        w_state_nxt  = (r_k == '0) ? ST_DRAIN : ST_FEED;
      end
      ST_FEED: begin
        w_feed_act = 1'b1;
        if (w_feed_last) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (w_flush_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_v_o = 1'b1;
        if (w_drain_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // One counter serves both FEED (cycle index c) and FLUSH; restarts on every state change.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if ((r_state == ST_FEED) || (r_state == ST_FLUSH)) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_row <= '0;
      r_k   <= '0;
    end else begin
      if (w_accept) begin
        r_k   <= cmd_k_i;
        r_row <= '0;
      end else if (w_drain_last) begin
        r_row <= '0;
      end else if (w_drain_fire) begin
        r_row <= r_row + 1'b1;
      end
    end
  end

  torus_skew_gen #(
    .N_P       (N_P),
    .K_WIDTH_P (K_WIDTH_P)
  ) u_skew (
    .i_act (w_feed_act),
    .i_cnt (r_cnt),
    .i_k   (r_k),
    .o_en  (w_en)
  );

  assign feed_row_en_o = w_en;
  assign feed_col_en_o = w_en;
  assign feed_idx_o    = w_feed_act ? r_cnt : '0;
  assign drain_row_o   = r_row;

`ifdef TORUS_CTRL_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [31:0] r_perf_stall;

  // Counting every non-IDLE cycle covers CLEAR through DONE inclusive.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else if (w_accept) begin
      r_perf_cycles <= '0;
      r_perf_stall  <= '0;
    end else if (r_state != ST_IDLE) begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
      if ((r_state == ST_DRAIN) && !drain_ready_i) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_cycles_o = r_perf_cycles;
  assign perf_stall_o  = r_perf_stall;
`endif

endmodule

`default_nettype wire
